// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch unit bundle of the imem request/response channels, decode queue and redirect.
interface fetch_queue_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              fetch_en_i;
  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [AWIDTH-1:0] mem_req_addr_o;
  logic              mem_rsp_valid_i;
  logic [DWIDTH-1:0] mem_rsp_data_i;
  logic              insn_valid_o;
  logic              insn_ready_i;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;
  modport master (
    input  fetch_en_i, redirect_i, redirect_pc_i, mem_req_ready_i,
    input  mem_rsp_valid_i, mem_rsp_data_i, insn_ready_i,
    output mem_req_valid_o, mem_req_addr_o, insn_valid_o, pc_o, insn_o
  );
  modport slave (
    output fetch_en_i, redirect_i, redirect_pc_i, mem_req_ready_i,
    output mem_rsp_valid_i, mem_rsp_data_i, insn_ready_i,
    input  mem_req_valid_o, mem_req_addr_o, insn_valid_o, pc_o, insn_o
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner issuing in-order imem reads, pairing responses with PCs into a decode FIFO.
module fetch_queue #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 'h01000000,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2
) (
  input logic            clk,
  input logic            rst,
  fetch_queue_if.master  bus
);
  localparam int QW = $clog2(DEPTH);
  localparam int IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(DEPTH + MAX_OUT) + 1;
  logic [AWIDTH-1:0] r_fpc;
  logic [CW-1:0]     r_cnt, r_outst, r_stale;
  logic [QW-1:0]     r_wr, r_rd;
  logic [IW-1:0]     r_iwr, r_ird;
  logic [AWIDTH-1:0] r_pcq [DEPTH];
  logic [DWIDTH-1:0] r_dq  [DEPTH];
  logic [AWIDTH-1:0] r_ipc [2**IW];
  logic              w_credit, w_req_valid, w_fire, w_rsp, w_drop, w_push, w_valid, w_pop;
  logic [CW-1:0]     w_outst_n;
  // Credits count both queued and in-flight instructions so every response always finds a free slot.
  assign w_credit    = (r_outst < CW'(MAX_OUT)) && ((r_cnt + r_outst) < CW'(DEPTH));
  assign w_req_valid = rst & bus.fetch_en_i & ~bus.redirect_i & w_credit;
  assign w_fire      = w_req_valid & bus.mem_req_ready_i;
  assign w_rsp       = bus.mem_rsp_valid_i & (r_outst != '0);
  assign w_drop      = w_rsp & ((r_stale != '0) | bus.redirect_i);
  assign w_push      = w_rsp & ~w_drop;
  assign w_valid     = r_cnt != '0;
  assign w_pop       = w_valid & bus.insn_ready_i & ~bus.redirect_i;
  assign w_outst_n   = r_outst + CW'(w_fire) - CW'(w_rsp);
  assign bus.mem_req_valid_o = w_req_valid;
  assign bus.mem_req_addr_o  = r_fpc;
  assign bus.insn_valid_o    = w_valid;
  assign bus.pc_o            = w_valid ? r_pcq[r_rd] : '0;
  assign bus.insn_o          = w_valid ? r_dq[r_rd] : '0;
  // Control state: fetch PC, in-flight and stale accounting, FIFO pointers with redirect flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fpc   <= BASEADDR;
      r_cnt   <= '0;
      r_outst <= '0;
      r_stale <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_iwr   <= '0;
      r_ird   <= '0;
    end else begin
      r_fpc   <= bus.redirect_i ? (bus.redirect_pc_i & ~AWIDTH'(3)) : w_fire ? r_fpc + AWIDTH'(4) : r_fpc;
      r_iwr   <= r_iwr + IW'(w_fire);
      r_ird   <= r_ird + IW'(w_rsp);
      r_outst <= w_outst_n;
      r_stale <= bus.redirect_i ? w_outst_n : r_stale - CW'(w_rsp && (r_stale != '0));
      r_wr    <= bus.redirect_i ? '0 : r_wr + QW'(w_push);
      r_rd    <= bus.redirect_i ? '0 : r_rd + QW'(w_pop);
      r_cnt   <= bus.redirect_i ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  // Storage: in-flight PCs on issue, paired {pc, insn} entries on accepted responses.
  always_ff @(posedge clk) begin
    if (w_fire) r_ipc[r_iwr] <= r_fpc;
    if (w_push) begin
      r_pcq[r_wr] <= r_ipc[r_ird];
      r_dq[r_wr]  <= bus.mem_rsp_data_i;
    end
  end
endmodule
